// File: rtl/magnetron_ctrl.sv
// Magnetron controller: IDLE/COOK/PAUSE/DONE FSM with cook-time countdown, duty-cycled power and door interlock.
// Latency: button presses and load act on the next clock edge; mag_on follows door_closed combinationally.
// Backpressure: none; each button press yields exactly one event, and holding a button does not repeat it.
//
// Ports:
//   clk, resetn          clock (rising edge), synchronous active-low reset
//   door_closed          1 = door shut (level)
//   startn/stopn/clearn  active-low buttons; each falling edge is one press
//   load, time_in,       in IDLE, latch cook time (s) and power level
//   power_in
//   mag_on               magnetron enable
//   time_left            remaining seconds
//   state                00 IDLE, 01 COOK, 10 PAUSE, 11 DONE
//   done                 high while in DONE
//   beep                 done beeper
//
// Build option: define MAGNETRON_BEEP_EN to enable the done beeper (BEEP_CYC ticks);
// otherwise beep is tied low.
module magnetron_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int TIME_W     = 12,
  parameter int PWR_LEVELS = 10,
  parameter int PWR_W      = 4,
  parameter int BEEP_CYC   = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              door_closed,
  input  logic              startn,
  input  logic              stopn,
  input  logic              clearn,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PWR_W-1:0]  power_in,
  output logic              mag_on,
  output logic [TIME_W-1:0] time_left,
  output logic [1:0]        state,
  output logic              done,
  output logic              beep
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COOK  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] time_q, time_d;
  logic [PWR_W-1:0]  power_q, power_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [PWR_W-1:0]  win_q, win_d;
  logic              startn_q, stopn_q, clearn_q;

  logic start_ev, stop_ev, clear_ev, any_ev;
  logic presc_run, tick;

  // Press = previous sample high, current sample low.
  assign start_ev = startn_q & ~startn;
  assign stop_ev  = stopn_q  & ~stopn;
  assign clear_ev = clearn_q & ~clearn;
  assign any_ev   = start_ev | stop_ev | clear_ev;

`ifdef MAGNETRON_BEEP_EN
  localparam int BC_W = (BEEP_CYC > 0) ? $clog2(BEEP_CYC + 1) : 1;
  logic [BC_W-1:0] beep_cnt_q, beep_cnt_d;

  // The prescaler also runs in DONE so the beep length is measured in ticks.
  assign presc_run = (state_q == S_COOK) | ((state_q == S_DONE) & (beep_cnt_q != '0));
  // Gated by state so leaving DONE early silences the beeper immediately.
  assign beep      = (state_q == S_DONE) & (beep_cnt_q != '0);
`else
  logic unused_beep_cfg;
  // Keeps BEEP_CYC referenced in builds without the beeper.
  assign unused_beep_cfg = (BEEP_CYC == 0);
  assign presc_run       = (state_q == S_COOK);
  assign beep            = 1'b0;
`endif

  assign tick = presc_run & (presc_q == PRE_W'(TICK_DIV - 1));

  // Combinational so an opening door cuts the magnetron in the same cycle.
  assign mag_on    = (state_q == S_COOK) & door_closed & (win_q < power_q);
  assign time_left = time_q;
  assign state     = state_q;
  assign done      = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    power_d = power_q;
    presc_d = presc_q;
    win_d   = win_q;
`ifdef MAGNETRON_BEEP_EN
    beep_cnt_d = beep_cnt_q;
    if (tick && state_q == S_DONE) begin
      beep_cnt_d = beep_cnt_q - BC_W'(1);
    end
`endif

    if (presc_run) begin
      presc_d = tick ? '0 : presc_q + PRE_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (clear_ev) begin
          time_d = '0;
        end else if (start_ev && door_closed && time_q != '0) begin
          state_d = S_COOK;
          presc_d = '0;
          win_d   = '0;
        end else if (load) begin
          time_d  = time_in;
          power_d = (power_in > PWR_W'(PWR_LEVELS)) ? PWR_W'(PWR_LEVELS) : power_in;
        end
      end

      S_COOK: begin
        // The tick is applied before any pause/stop decision in the same cycle.
        if (tick) begin
          win_d = (win_q >= PWR_W'(PWR_LEVELS - 1)) ? '0 : win_q + PWR_W'(1);
          if (time_q != '0) begin
            time_d = time_q - TIME_W'(1);
          end
        end
        if (tick && time_q == TIME_W'(1)) begin
          state_d = S_DONE;
`ifdef MAGNETRON_BEEP_EN
          beep_cnt_d = BC_W'(BEEP_CYC);
`endif
        end else if (!door_closed) begin
          state_d = S_PAUSE;
        end else if (clear_ev) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (stop_ev) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        // Prescaler and window counter hold here, so resume keeps the phase.
        if (clear_ev || stop_ev) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (start_ev && door_closed) begin
          state_d = S_COOK;
        end
      end

      S_DONE: begin
        time_d = '0;
        if (!door_closed || any_ev) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      time_q   <= '0;
      power_q  <= PWR_W'(PWR_LEVELS);
      presc_q  <= '0;
      win_q    <= '0;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      clearn_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      power_q  <= power_d;
      presc_q  <= presc_d;
      win_q    <= win_d;
      startn_q <= startn;
      stopn_q  <= stopn;
      clearn_q <= clearn;
    end
  end

`ifdef MAGNETRON_BEEP_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      beep_cnt_q <= '0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_magnetron_ctrl.sv
// Directed bench for magnetron_ctrl with TICK_DIV=4, PWR_LEVELS=10.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Reports a single summary line at the end.
module tb_magnetron_ctrl;

  localparam int TIME_W = 12;
  localparam int PWR_W  = 4;
`ifdef MAGNETRON_BEEP_EN
  localparam int BEEP_EXP = 12;
`else
  localparam int BEEP_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              door_closed = 1'b1;
  logic              startn = 1'b1;
  logic              stopn = 1'b1;
  logic              clearn = 1'b1;
  logic              load = 1'b0;
  logic [TIME_W-1:0] time_in = '0;
  logic [PWR_W-1:0]  power_in = '0;
  logic              mag_on;
  logic [TIME_W-1:0] time_left;
  logic [1:0]        state;
  logic              done;
  logic              beep;

  int n_checks = 0;
  int n_fail   = 0;

  magnetron_ctrl #(
    .TICK_DIV(4), .TIME_W(TIME_W), .PWR_LEVELS(10), .PWR_W(PWR_W), .BEEP_CYC(3)
  ) dut (
    .clk(clk), .resetn(resetn), .door_closed(door_closed),
    .startn(startn), .stopn(stopn), .clearn(clearn), .load(load),
    .time_in(time_in), .power_in(power_in),
    .mag_on(mag_on), .time_left(time_left), .state(state), .done(done), .beep(beep)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // which: 0 start, 1 stop, 2 clear. One cycle low, then released.
  task automatic press(input int which);
    case (which)
      0: startn = 1'b0;
      1: stopn  = 1'b0;
      default: clearn = 1'b0;
    endcase
    step();
    startn = 1'b1;
    stopn  = 1'b1;
    clearn = 1'b1;
  endtask

  task automatic do_load(input int t, input int p);
    time_in  = TIME_W'(t);
    power_in = PWR_W'(p);
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  int on_cnt;
  int bc;

  initial begin
    // Reset state
    step(2);
    resetn = 1'b1;
    chk("rst_state", state, 0);
    chk("rst_time", time_left, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_done", done, 0);
    chk("rst_beep", beep, 0);

    // 1: 3 s at full power
    do_load(3, 10);
    chk("t1_load", time_left, 3);
    press(0);
    chk("t1_cook", state, 1);
    on_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      if (mag_on) on_cnt++;
      if (k == 4) chk("t1_time2", time_left, 2);
      if (k == 8) chk("t1_time1", time_left, 1);
    end
    step();
    chk("t1_on_cycles", on_cnt, 12);
    chk("t1_state_done", state, 3);
    chk("t1_done", done, 1);
    chk("t1_mag_off", mag_on, 0);
    chk("t1_time0", time_left, 0);
    chk("t1_beep_start", beep, (BEEP_EXP != 0) ? 1 : 0);
    // Stop pressed early in DONE: beep and done drop with the state change
    step(4);
    press(1);
    chk("t1_stop_idle", state, 0);
    chk("t1_stop_done", done, 0);
    chk("t1_stop_beep", beep, 0);

    // 2: 20 s at power 3 -> 3 ticks on, 7 off
    do_load(20, 3);
    press(0);
    for (int k = 0; k < 80; k++) begin
      if (k > 0) step();
      chk($sformatf("t2_duty_k%0d", k), mag_on, (((k / 4) % 10) < 3) ? 1 : 0);
      if (k == 79) chk("t2_time1", time_left, 1);
    end
    step();
    chk("t2_time0", time_left, 0);
    chk("t2_done", state, 3);
    bc = 0;
    for (int d = 0; d < 20; d++) begin
      if (d > 0) step();
      if (beep) bc++;
    end
    chk("t2_beep_len", bc, BEEP_EXP);
    chk("t2_still_done", done, 1);
    door_closed = 1'b0;
    step();
    chk("t2_door_idle", state, 0);
    door_closed = 1'b1;

    // 3: door opened mid-cook at time_left=5, resume keeps prescaler phase
    do_load(8, 10);
    press(0);                  // k=0
    step(2);                   // k=2
    time_in = TIME_W'(99);
    load = 1'b1;
    step();                    // k=3
    load = 1'b0;
    chk("t3_load_ignored", time_left, 8);
    step(10);                  // k=13
    chk("t3_time5", time_left, 5);
    door_closed = 1'b0;
    #1;
    chk("t3_mag_drop", mag_on, 0);
    chk("t3_still_cook", state, 1);
    step();
    chk("t3_pause", state, 2);
    chk("t3_pause_time", time_left, 5);
    step(5);
    chk("t3_frozen", time_left, 5);
    door_closed = 1'b1;
    press(0);
    chk("t3_resume", state, 1);
    chk("t3_resume_mag", mag_on, 1);
    step();
    chk("t3_phase_a", time_left, 5);
    step();
    chk("t3_phase_b", time_left, 4);

    // 4: start and stop together in COOK -> PAUSE; clear -> IDLE
    startn = 1'b0;
    stopn  = 1'b0;
    step();
    startn = 1'b1;
    stopn  = 1'b1;
    chk("t4_pause", state, 2);
    chk("t4_time", time_left, 4);
    press(2);
    chk("t4_idle", state, 0);
    chk("t4_cleared", time_left, 0);

    // 5: start with zero time ignored; reset mid-cook
    press(0);
    chk("t5_no_start", state, 0);
    do_load(5, 10);
    press(0);
    chk("t5_cook", state, 1);
    step(3);
    resetn = 1'b0;
    step();
    chk("t5_rst_state", state, 0);
    chk("t5_rst_mag", mag_on, 0);
    chk("t5_rst_time", time_left, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_beep", beep, 0);
    resetn = 1'b1;
    step();

    // Power 0: timer runs, magnetron never on
    do_load(2, 0);
    press(0);
    on_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      if (mag_on) on_cnt++;
    end
    step();
    chk("p0_on_cycles", on_cnt, 0);
    chk("p0_done", state, 3);
    press(2);
    chk("p0_idle", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
